cache_axi_rd_arbiter: RTL and testbench

Shares the single AXI4 read channel (AR/R) between the instruction cache and the data cache.
- Latches one request at a time and drives the AR handshake.
- Steers R beats back to the granted cache, matching the r_req / r_rdy_AXI / r_data_ready / fill_finish protocol of the cache main FSMs.
- Sits between both cache controllers and the top-level AXI master bridge.

---
 rtl/cache_axi_rd_arbiter_pkg.sv | 23 ++
 rtl/cache_axi_rd_arbiter_if.sv | 65 ++++++
 rtl/cache_axi_rd_arbiter_pick.sv | 40 ++++
 rtl/cache_axi_rd_arbiter.sv | 147 ++++++++++++++
 tb/tb_cache_axi_rd_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_axi_rd_arbiter_pkg.sv
// rtl/cache_axi_rd_arbiter_pkg.sv - shared constants and types for the cache AXI read arbiter
package cache_axi_rd_arbiter_pkg;

  // One-hot controller states
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_AR   = 3'b010;
  localparam logic [2:0] ST_R    = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [3:0] ID_I_DEF = 4'd0;
  localparam logic [3:0] ID_D_DEF = 4'd1;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_idx_e;

  function automatic req_idx_e other_req(input req_idx_e r);
    return (r == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter_if.sv
// rtl/cache_axi_rd_arbiter_if.sv - icache/dcache request, return and AXI AR/R signal bundle
interface cache_axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_r_req;
  logic [ADDR_W-1:0] i_r_addr;
  logic [7:0]        i_r_length;
  logic [2:0]        i_r_size;
  logic              i_r_rdy;
  logic              i_r_data_ready;
  logic              i_ret_valid;
  logic              i_ret_last;

  logic              d_r_req;
  logic [ADDR_W-1:0] d_r_addr;
  logic [7:0]        d_r_length;
  logic [2:0]        d_r_size;
  logic              d_r_rdy;
  logic              d_r_data_ready;
  logic              d_ret_valid;
  logic              d_ret_last;
  logic              d_uncache;
  logic              wr_busy;

  logic [DATA_W-1:0] ret_data;
  logic              ret_err;

  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // Arbiter view: drives AR and the cache-facing returns
  modport master (
    input  i_r_req, i_r_addr, i_r_length, i_r_size, i_r_data_ready,
    output i_r_rdy, i_ret_valid, i_ret_last,
    input  d_r_req, d_r_addr, d_r_length, d_r_size, d_r_data_ready, d_uncache, wr_busy,
    output d_r_rdy, d_ret_valid, d_ret_last,
    output ret_data, ret_err,
    output araddr, arid, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  // Environment view: caches plus AXI slave side
  modport slave (
    output i_r_req, i_r_addr, i_r_length, i_r_size, i_r_data_ready,
    input  i_r_rdy, i_ret_valid, i_ret_last,
    output d_r_req, d_r_addr, d_r_length, d_r_size, d_r_data_ready, d_uncache, wr_busy,
    input  d_r_rdy, d_ret_valid, d_ret_last,
    input  ret_data, ret_err,
    input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/cache_axi_rd_arbiter_pick.sv
// rtl/cache_axi_rd_arbiter_pick.sv - two-way read request picker; CLAP_RD_ARB_RR_EN enables round-robin
module cache_axi_rd_arbiter_pick
  import cache_axi_rd_arbiter_pkg::*;
(
  input  logic     i_icache_req,
  input  logic     i_dcache_req,
  input  logic     i_d_uncache,
  input  logic     i_wr_busy,
`ifdef CLAP_RD_ARB_RR_EN
  input  req_idx_e i_rr_ptr,
`endif
  output logic     o_valid,
  output req_idx_e o_sel
);

  logic w_i_elig;
  logic w_d_elig;

  // An uncached dcache read must not overtake an outstanding uncached write
  assign w_d_elig = i_dcache_req && !(i_d_uncache && i_wr_busy);
  assign w_i_elig = i_icache_req;

  // Select the winner among eligible requesters
  always_comb begin
    o_valid = w_i_elig || w_d_elig;
    o_sel   = REQ_I;
`ifdef CLAP_RD_ARB_RR_EN
    if (w_i_elig && w_d_elig) begin
      o_sel = i_rr_ptr;
    end else if (w_d_elig) begin
      o_sel = REQ_D;
    end
`else
    if (w_d_elig) begin
      o_sel = REQ_D;
    end
`endif
  end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// rtl/cache_axi_rd_arbiter.sv - shares the AXI read channel between icache and dcache; CLAP_RD_ARB_RR_EN selects round-robin
module cache_axi_rd_arbiter
  import cache_axi_rd_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] ID_I   = ID_I_DEF,
  parameter logic [3:0] ID_D   = ID_D_DEF
)(
  input  logic                   clk,
  input  logic                   rstn,
  cache_axi_rd_arbiter_if.master bus
);

  logic [2:0]        r_state;
  logic              r_gnt_vld;
  req_idx_e          r_gnt;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;
  logic [3:0]        r_arid;
  logic [7:0]        r_cnt;
  logic              r_err;
`ifdef CLAP_RD_ARB_RR_EN
  req_idx_e          r_ptr;
`endif

  logic              w_pick_valid;
  req_idx_e          w_pick_sel;
  logic              w_gnt_i;
  logic              w_gnt_d;
  logic              w_dready;
  logic              w_ar_hs;
  logic              w_beat;
  logic              w_beat_err;
  logic [DATA_W-1:0] w_rdata;

  cache_axi_rd_arbiter_pick u_pick (
    .i_icache_req (bus.i_r_req),
    .i_dcache_req (bus.d_r_req),
    .i_d_uncache  (bus.d_uncache),
    .i_wr_busy    (bus.wr_busy),
`ifdef CLAP_RD_ARB_RR_EN
    .i_rr_ptr     (r_ptr),
`endif
    .o_valid      (w_pick_valid),
    .o_sel        (w_pick_sel)
  );

  assign w_gnt_i  = r_gnt_vld && (r_gnt == REQ_I);
  assign w_gnt_d  = r_gnt_vld && (r_gnt == REQ_D);
  assign w_dready = (w_gnt_i && bus.i_r_data_ready) || (w_gnt_d && bus.d_r_data_ready);

  assign bus.arvalid = (r_state == ST_AR);
  assign bus.araddr  = r_araddr;
  assign bus.arlen   = r_arlen;
  assign bus.arsize  = r_arsize;
  assign bus.arid    = r_arid;
  assign bus.arburst = BURST_INCR;
  assign w_ar_hs     = bus.arvalid && bus.arready;

  assign bus.i_r_rdy = w_ar_hs && w_gnt_i;
  assign bus.d_r_rdy = w_ar_hs && w_gnt_d;

  // The granted cache's readiness is the only back-pressure on R
  assign bus.rready = (r_state == ST_R) && w_dready;
  assign w_beat     = bus.rvalid && bus.rready;

  assign w_rdata          = bus.rdata;
  assign bus.ret_data     = w_rdata;
  assign bus.i_ret_valid  = w_beat && w_gnt_i;
  assign bus.d_ret_valid  = w_beat && w_gnt_d;
  assign bus.i_ret_last   = w_beat && w_gnt_i && bus.rlast;
  assign bus.d_ret_last   = w_beat && w_gnt_d && bus.rlast;
  assign bus.ret_err      = r_err;

  // Bad response, foreign ID or a burst that ends at the wrong beat count
  assign w_beat_err = (bus.rresp != 2'b00) || (bus.rid != r_arid) ||
                      (bus.rlast && (r_cnt != r_arlen));

  // Request latch, AR handshake and R beat tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_gnt_vld <= 1'b0;
      r_gnt     <= REQ_I;
      r_araddr  <= '0;
      r_arlen   <= 8'd0;
      r_arsize  <= 3'd0;
      r_arid    <= 4'd0;
      r_cnt     <= 8'd0;
`ifdef CLAP_RD_ARB_RR_EN
      r_ptr     <= REQ_I;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state   <= ST_AR;
            r_gnt_vld <= 1'b1;
            r_gnt     <= w_pick_sel;
            if (w_pick_sel == REQ_D) begin
              r_araddr <= bus.d_r_addr;
              r_arlen  <= bus.d_r_length;
              r_arsize <= bus.d_r_size;
              r_arid   <= ID_D;
            end else begin
              r_araddr <= bus.i_r_addr;
              r_arlen  <= bus.i_r_length;
              r_arsize <= bus.i_r_size;
              r_arid   <= ID_I;
            end
          end
        end
        ST_AR: begin
          if (w_ar_hs) begin
            r_cnt   <= 8'd0;
            r_state <= ST_R;
          end
        end
        ST_R: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 8'd1;
            if (bus.rlast) begin
              r_state   <= ST_IDLE;
              r_gnt_vld <= 1'b0;
`ifdef CLAP_RD_ARB_RR_EN
              r_ptr     <= other_req(r_gnt);
`endif
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_beat && w_beat_err) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// tb/tb_cache_axi_rd_arbiter.sv - self-checking bench for cache_axi_rd_arbiter; honours CLAP_RD_ARB_RR_EN
module tb_cache_axi_rd_arbiter;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  bit   exp_err;

  bit          p_req  [2];
  logic [31:0] p_addr [2];
  logic [7:0]  p_len  [2];
  logic [2:0]  p_size [2];
  bit          p_unc;
`ifdef CLAP_RD_ARB_RR_EN
  bit          turn;
`endif

  cache_axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_axi_rd_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .ID_I   (4'd0),
    .ID_D   (4'd1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_r_req = 0; bus.i_r_addr = 0; bus.i_r_length = 0; bus.i_r_size = 0; bus.i_r_data_ready = 0;
    bus.d_r_req = 0; bus.d_r_addr = 0; bus.d_r_length = 0; bus.d_r_size = 0; bus.d_r_data_ready = 0;
    bus.d_uncache = 0; bus.wr_busy = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_i_r_rdy", bus.i_r_rdy, 0);
    chk("rst_d_r_rdy", bus.d_r_rdy, 0);
    chk("rst_i_ret_valid", bus.i_ret_valid, 0);
    chk("rst_d_ret_valid", bus.d_ret_valid, 0);
    chk("rst_i_ret_last", bus.i_ret_last, 0);
    chk("rst_d_ret_last", bus.d_ret_last, 0);
    chk("rst_ret_err", bus.ret_err, 0);
  endtask

  // Reset is asserted with inputs untouched so the async clear is visible
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    clear_inputs();
    p_req[0] = 0; p_req[1] = 0; p_unc = 0;
    exp_err = 0;
`ifdef CLAP_RD_ARB_RR_EN
    turn = 0;
`endif
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic post_req(input bit w, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input bit unc);
    p_req[w] = 1; p_addr[w] = a; p_len[w] = l; p_size[w] = s;
    if (w) begin
      bus.d_r_req = 1; bus.d_r_addr = a; bus.d_r_length = l; bus.d_r_size = s;
      bus.d_uncache = unc; p_unc = unc;
    end else begin
      bus.i_r_req = 1; bus.i_r_addr = a; bus.i_r_length = l; bus.i_r_size = s;
    end
  endtask

  // Policy: dcache first, or with RR the cache the turn bit names on a tie
  function automatic bit model_winner(input bit ie, input bit de);
    if (ie && de) begin
`ifdef CLAP_RD_ARB_RR_EN
      return turn;
`else
      return 1'b1;
`endif
    end
    return de;
  endfunction

  function automatic bit d_eligible();
    return p_req[1] && !(p_unc && bus.wr_busy);
  endfunction

  task automatic run_burst(input bit w, input int ar_delay, input bit toggle,
                           input int err_beat, input int nb_in, input bit send_last);
    logic [3:0]  id;
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    int          nb;
    int          waited;
    int          k;
    int          guard;
    bit          dr, rv, lst;
    logic [31:0] dat;
    id = w ? 4'd1 : 4'd0;
    a = p_addr[w]; l = p_len[w]; s = p_size[w];
    nb = (nb_in < 0) ? int'(l) + 1 : nb_in;

    chk("ar_not_yet", bus.arvalid, 0);
    waited = 0;
    while (!bus.arvalid && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("ar_latency", 64'(waited), 64'd1);
    if (!bus.arvalid) return;
    chk("araddr", bus.araddr, a);
    chk("arid", bus.arid, id);
    chk("arlen", bus.arlen, l);
    chk("arsize", bus.arsize, s);
    chk("arburst", bus.arburst, 2'b01);

    for (int c = 0; c < ar_delay; c++) begin
      chk("i_r_rdy_early", bus.i_r_rdy, 0);
      chk("d_r_rdy_early", bus.d_r_rdy, 0);
      @(negedge clk); #1;
      chk("ar_hold_valid", bus.arvalid, 1);
      chk("ar_hold_addr", bus.araddr, a);
      chk("ar_hold_len", bus.arlen, l);
      chk("ar_hold_id", bus.arid, id);
    end
    bus.arready = 1; #1;
    chk("rdy_granted", w ? bus.d_r_rdy : bus.i_r_rdy, 1);
    chk("rdy_other", w ? bus.i_r_rdy : bus.d_r_rdy, 0);
    @(negedge clk);
    bus.arready = 0;
    if (w) bus.d_r_req = 0; else bus.i_r_req = 0;
    p_req[w] = 0;
    #1;
    chk("ar_done_valid", bus.arvalid, 0);
    chk("rdy_pulse_i", bus.i_r_rdy, 0);
    chk("rdy_pulse_d", bus.d_r_rdy, 0);

    k = 0; guard = 0;
    while (k < nb && guard < 400) begin
      dr  = toggle ? bit'($urandom_range(0, 1)) : 1'b1;
      rv  = ($urandom_range(0, 3) != 0);
      lst = send_last && (k == nb - 1);
      dat = $urandom;
      if (w) begin
        bus.d_r_data_ready = dr; bus.i_r_data_ready = bit'($urandom_range(0, 1));
      end else begin
        bus.i_r_data_ready = dr; bus.d_r_data_ready = bit'($urandom_range(0, 1));
      end
      bus.rvalid = rv; bus.rdata = dat; bus.rid = id; bus.rlast = lst;
      bus.rresp = (k == err_beat) ? 2'b10 : 2'b00;
      #1;
      chk("rready", bus.rready, dr);
      chk("ret_data", bus.ret_data, dat);
      chk("ret_valid_gnt", w ? bus.d_ret_valid : bus.i_ret_valid, rv && dr);
      chk("ret_valid_other", w ? bus.i_ret_valid : bus.d_ret_valid, 0);
      chk("ret_last_gnt", w ? bus.d_ret_last : bus.i_ret_last, rv && dr && lst);
      chk("ret_last_other", w ? bus.i_ret_last : bus.d_ret_last, 0);
      if (rv && dr) k++;
      guard++;
      @(negedge clk);
    end
    chk("beats_done", 64'(k), 64'(nb));
    bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
    if (err_beat >= 0 && err_beat < nb) exp_err = 1;
    if (send_last) begin
      if (nb != int'(l) + 1) exp_err = 1;
`ifdef CLAP_RD_ARB_RR_EN
      turn = !w;
`endif
      #1;
      chk("idle_after_last", bus.arvalid, 0);
      chk("ret_err", bus.ret_err, exp_err);
    end
  endtask

  task automatic serve(input int ar_delay, input bit toggle, input int err_beat,
                       input int nb, input bit send_last);
    bit ie, de;
    ie = p_req[0];
    de = d_eligible();
    chk("something_eligible", ie || de, 1);
    if (!(ie || de)) return;
    run_burst(model_winner(ie, de), ar_delay, toggle, err_beat, nb, send_last);
  endtask

  initial begin
    total = 0; bad = 0;
    clear_inputs();
    rstn = 1'b1;
    #2;
    do_reset();

    // icache alone, 16 beats
    post_req(0, 32'h1C00_0040, 8'd15, 3'd2, 0);
    serve(0, 0, -1, -1, 1);

    // simultaneous requests over four bursts
    do_reset();
    for (int r = 0; r < 2; r++) begin
      post_req(0, 32'h0000_1000 + 32'(r * 64), 8'd3, 3'd2, 0);
      post_req(1, 32'h8000_2000 + 32'(r * 64), 8'd2, 3'd2, 0);
      serve(0, 0, -1, -1, 1);
      serve(0, 0, -1, -1, 1);
    end

    // uncached dcache read held off by an outstanding write
    bus.wr_busy = 1;
    post_req(1, 32'hBFD0_0010, 8'd0, 3'd1, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("wr_busy_block", bus.arvalid, 0);
      chk("wr_busy_no_rdy", bus.d_r_rdy, 0);
    end
    bus.wr_busy = 0;
    serve(0, 0, -1, -1, 1);

    // slow arready
    post_req(1, 32'h0000_3300, 8'd3, 3'd2, 0);
    serve(7, 0, -1, -1, 1);

    // back-pressure from the icache
    post_req(0, 32'h1C00_0400, 8'd15, 3'd2, 0);
    serve(0, 1, -1, -1, 1);

    // randomized mix
    for (int it = 0; it < 14; it++) begin
      if (!p_req[0] && $urandom_range(0, 1) == 1)
        post_req(0, $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)), 0);
      if (!p_req[1] && $urandom_range(0, 1) == 1)
        post_req(1, $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)),
                 bit'($urandom_range(0, 1)));
      if (!p_req[0] && !p_req[1])
        post_req(0, $urandom, 8'($urandom_range(0, 7)), 3'd2, 0);
      bus.wr_busy = bit'($urandom_range(0, 1));
      if (!p_req[0] && !d_eligible()) begin
        repeat (3) begin
          @(negedge clk); #1;
          chk("rand_blocked", bus.arvalid, 0);
        end
        bus.wr_busy = 0;
      end
      serve($urandom_range(0, 3), 1, -1, -1, 1);
    end

    // error response on beat 3 is sticky across a clean burst
    do_reset();
    post_req(0, 32'h1C00_0800, 8'd15, 3'd2, 0);
    serve(0, 0, 3, -1, 1);
    post_req(0, 32'h1C00_0900, 8'd0, 3'd2, 0);
    serve(0, 0, -1, -1, 1);

    // early rlast at beat 7 of a 16-beat burst
    do_reset();
    post_req(0, 32'h1C00_0A00, 8'd15, 3'd2, 0);
    serve(0, 0, -1, 8, 1);

    // reset in the middle of a dcache burst
    post_req(1, 32'h0000_4400, 8'd7, 3'd2, 0);
    serve(0, 0, -1, 3, 0);
    bus.rvalid = 1; bus.d_r_data_ready = 1; bus.rid = 4'd1; bus.rdata = 32'hA5A5_5A5A;
    #1;
    chk("pre_reset_beat", bus.d_ret_valid, 1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
